// File: rtl/sd_spi_card_responder_if.sv
// SPI-mode SD card bus between host controller and card model.
// Mode 0: host drives spi_clk/cs/mosi, card drives miso.
interface sd_spi_card_responder_if;
  logic spi_clk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (
    output spi_clk,
    output cs,
    output mosi,
    input  miso
  );

  modport slave (
    input  spi_clk,
    input  cs,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card responder: command decode, R1/R3/R7 replies,
// single-block read/write against an external byte-wide store.
module sd_spi_card_responder #(
  parameter int unsigned ACMD41_RETRIES = 2,
  parameter int unsigned NCR_BYTES      = 1,
  parameter int unsigned RD_GAP_BYTES   = 2,
  parameter int unsigned WR_BUSY_BYTES  = 4,
  parameter logic [31:0] OCR_VALUE      = 32'hC0FF8000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  sd_spi_card_responder_if.slave        spi,
  output logic [31:0]                   blk_addr,
  output logic [8:0]                    byte_idx,
  input  logic [7:0]                    rd_data,
  output logic                          wr_en,
  output logic [7:0]                    wr_data,
  output logic                          cmd_valid,
  output logic [5:0]                    cmd_index,
  output logic                          initialized
);

  typedef enum logic [3:0] {
    HUNT,
    CMD_RX,
    NCR,
    RESP,
    RD_GAP,
    RD_TOKEN,
    RD_DATA,
    RD_CRC,
    WR_TOKEN,
    WR_DATA,
    WR_CRC,
    WR_DRESP,
    WR_BUSY
  } state_t;

  localparam logic [9:0] NCR_LAST  = 10'(NCR_BYTES - 1);
  localparam logic [9:0] GAP_LAST  = 10'(RD_GAP_BYTES - 1);
  localparam logic [9:0] BUSY_LAST = 10'(WR_BUSY_BYTES - 1);
  localparam logic [9:0] BLK_LAST  = 10'd511;

  logic [2:0]  sclk_q;
  logic [1:0]  mosi_q;
  logic [1:0]  cs_q;
  logic        sel;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        mosi_s;

  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr;
  logic        load_pend;
  logic        rx_done;
  logic [7:0]  rx_byte;
  logic        rd_load;

  state_t      state;
  state_t      state_d;
  state_t      post_st;
  logic [9:0]  cnt;
  logic [9:0]  cnt_d;
  logic [7:0]  tx_next;
  logic [7:0]  tx_d;
  logic [39:0] resp_sr;
  logic [39:0] resp_d;
  logic [2:0]  resp_cnt;
  logic [2:0]  rcnt_d;
  logic        fire;
  logic        wr_fire;
  logic        start;
  logic        arg_shift;

  logic [5:0]  cmd_q;
  logic [31:0] arg_sr;
  logic        in_idle;
  logic        app_cmd;
  logic [7:0]  retry_cnt;

  logic        dec_idle;
  logic        dec_init;
  logic        dec_app;
  logic        dec_ill;
  logic        dec_blk;
  logic [7:0]  dec_retry;
  logic [7:0]  dec_r1;
  logic [31:0] dec_tail;
  logic [2:0]  dec_len;
  state_t      dec_post;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
      cs_q   <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_clk};
      mosi_q <= {mosi_q[0], spi.mosi};
      cs_q   <= {cs_q[0], spi.cs};
    end
  end

  assign sel       = ~cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];

  assign rx_done = sel & sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte = {rx_sr, mosi_s};
  assign rd_load = sel & sclk_fall & load_pend & (state == RD_DATA);

  // While deselected the shifter idles at 0xFF, so cs falling starts clean.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'hFF;
      load_pend <= 1'b0;
    end else if (!sel) begin
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'hFF;
      load_pend <= 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_sr   <= {rx_sr[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) load_pend <= 1'b1;
      end
      if (sclk_fall) begin
        if (load_pend) begin
          tx_sr     <= (state == RD_DATA) ? rd_data : tx_next;
          load_pend <= 1'b0;
        end else begin
          tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end
    end
  end

  assign spi.miso = tx_sr[7] | spi.cs;

  // R1[0] reflects idle state after the command takes effect.
  always_comb begin
    dec_idle  = in_idle;
    dec_init  = initialized;
    dec_app   = 1'b0;
    dec_ill   = 1'b0;
    dec_blk   = 1'b0;
    dec_retry = retry_cnt;
    dec_tail  = 32'h0;
    dec_len   = 3'd1;
    dec_post  = HUNT;
    unique case (1'b1)
      (cmd_q == 6'd0): begin
        dec_idle  = 1'b1;
        dec_init  = 1'b0;
        dec_retry = 8'd0;
      end
      (cmd_q == 6'd8): begin
        dec_tail = {16'h0, arg_sr[15:0]};
        dec_len  = 3'd5;
      end
      (cmd_q == 6'd55): begin
        dec_app = 1'b1;
      end
      (cmd_q == 6'd41 && app_cmd): begin
        if (32'(retry_cnt) < ACMD41_RETRIES) begin
          dec_retry = retry_cnt + 8'd1;
        end else begin
          dec_idle = 1'b0;
          dec_init = 1'b1;
        end
      end
      (cmd_q == 6'd58): begin
        dec_tail = OCR_VALUE;
        dec_len  = 3'd5;
      end
      (cmd_q == 6'd17 && initialized): begin
        dec_blk  = 1'b1;
        dec_post = RD_GAP;
      end
      (cmd_q == 6'd24 && initialized): begin
        dec_blk  = 1'b1;
        dec_post = WR_TOKEN;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
    dec_r1 = {5'b0, dec_ill, 1'b0, dec_idle};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tx_d      = tx_next;
    resp_d    = resp_sr;
    rcnt_d    = resp_cnt;
    fire      = 1'b0;
    wr_fire   = 1'b0;
    start     = 1'b0;
    arg_shift = 1'b0;
    if (!sel) begin
      state_d = HUNT;
      tx_d    = 8'hFF;
    end else if (rx_done) begin
      unique case (state)
        HUNT: begin
          tx_d = 8'hFF;
          if (rx_byte[7:6] == 2'b01) begin
            start   = 1'b1;
            state_d = CMD_RX;
            cnt_d   = 10'd0;
          end
        end
        CMD_RX: begin
          tx_d = 8'hFF;
          if (cnt == 10'd4) begin
            fire    = 1'b1;
            state_d = NCR;
            cnt_d   = 10'd0;
            resp_d  = {dec_r1, dec_tail};
            rcnt_d  = dec_len - 3'd1;
          end else begin
            arg_shift = 1'b1;
            cnt_d     = cnt + 10'd1;
          end
        end
        NCR: begin
          tx_d = 8'hFF;
          if (cnt == NCR_LAST) begin
            state_d = RESP;
            tx_d    = resp_sr[39:32];
            resp_d  = {resp_sr[31:0], 8'hFF};
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        RESP: begin
          if (resp_cnt == 3'd0) begin
            state_d = post_st;
            tx_d    = 8'hFF;
            cnt_d   = 10'd0;
          end else begin
            tx_d   = resp_sr[39:32];
            resp_d = {resp_sr[31:0], 8'hFF};
            rcnt_d = resp_cnt - 3'd1;
          end
        end
        RD_GAP: begin
          tx_d = 8'hFF;
          if (cnt == GAP_LAST) begin
            state_d = RD_TOKEN;
            tx_d    = 8'hFE;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        RD_TOKEN: begin
          state_d = RD_DATA;
          cnt_d   = 10'd0;
        end
        RD_DATA: begin
          if (cnt == BLK_LAST) begin
            state_d = RD_CRC;
            cnt_d   = 10'd0;
            tx_d    = 8'hFF;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        RD_CRC: begin
          tx_d = 8'hFF;
          if (cnt == 10'd1) state_d = HUNT;
          else              cnt_d   = cnt + 10'd1;
        end
        WR_TOKEN: begin
          tx_d = 8'hFF;
          if (rx_byte == 8'hFE) begin
            state_d = WR_DATA;
            cnt_d   = 10'd0;
          end
        end
        WR_DATA: begin
          tx_d    = 8'hFF;
          wr_fire = 1'b1;
          if (cnt == BLK_LAST) begin
            state_d = WR_CRC;
            cnt_d   = 10'd0;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        WR_CRC: begin
          tx_d = 8'hFF;
          if (cnt == 10'd1) begin
            state_d = WR_DRESP;
            tx_d    = 8'h05;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        WR_DRESP: begin
          state_d = WR_BUSY;
          cnt_d   = 10'd0;
          tx_d    = 8'h00;
        end
        WR_BUSY: begin
          tx_d = 8'h00;
          if (cnt == BUSY_LAST) begin
            state_d = HUNT;
            tx_d    = 8'hFF;
          end else begin
            cnt_d = cnt + 10'd1;
          end
        end
        default: begin
          state_d = HUNT;
          tx_d    = 8'hFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 10'd0;
      tx_next  <= 8'hFF;
      resp_sr  <= 40'hFF_FFFF_FFFF;
      resp_cnt <= 3'd0;
      post_st  <= HUNT;
      cmd_q    <= 6'd0;
      arg_sr   <= 32'd0;
    end else begin
      cnt      <= cnt_d;
      tx_next  <= tx_d;
      resp_sr  <= resp_d;
      resp_cnt <= rcnt_d;
      if (start)     cmd_q   <= rx_byte[5:0];
      if (arg_shift) arg_sr  <= {arg_sr[23:0], rx_byte};
      if (fire)      post_st <= dec_post;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_index   <= 6'd0;
      in_idle     <= 1'b1;
      app_cmd     <= 1'b0;
      initialized <= 1'b0;
      retry_cnt   <= 8'd0;
      blk_addr    <= 32'd0;
      byte_idx    <= 9'd0;
      wr_en       <= 1'b0;
      wr_data     <= 8'd0;
    end else begin
      cmd_valid <= fire;
      wr_en     <= wr_fire;
      if (wr_fire) wr_data <= rx_byte;
      if (fire) begin
        cmd_index   <= cmd_q;
        in_idle     <= dec_idle;
        app_cmd     <= dec_app;
        initialized <= dec_init;
        retry_cnt   <= dec_retry;
      end
      // Write strobe sits at the old index; advance the cycle after.
      if (fire && dec_blk) begin
        blk_addr <= arg_sr;
        byte_idx <= 9'd0;
      end else if (wr_en || rd_load) begin
        byte_idx <= byte_idx + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench for sd_spi_card_responder acting as an SD host.
// Store model returns byte_idx[7:0]; write strobes checked live.
module tb_sd_spi_card_responder;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] blk_addr;
  logic [8:0]  byte_idx;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic        initialized;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cv_cnt = 0;
  logic [5:0]  cv_idx = 6'd0;
  int          wr_cnt = 0;
  logic [8:0]  wr_exp_idx = 9'd0;

  always #5 clk = ~clk;

  sd_spi_card_responder_if spi ();

  assign rd_data = byte_idx[7:0];

  sd_spi_card_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi),
    .blk_addr    (blk_addr),
    .byte_idx    (byte_idx),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .initialized (initialized)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_cnt++;
      cv_idx = cmd_index;
    end
    if (wr_en) begin
      check("wr_data", 32'(wr_data), 32'h0000_00A5);
      check("wr_idx", 32'(byte_idx), 32'(wr_exp_idx));
      wr_exp_idx++;
      wr_cnt++;
    end
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = tx[i];
      #HALF;
      rx[i] = spi.miso;
      spi.spi_clk = 1'b1;
      #HALF;
      spi.spi_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg,
                          input logic [7:0] crc);
    logic [47:0] f;
    logic [7:0]  r;
    f = {2'b01, idx, arg, crc};
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], r);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] tx,
                             input logic [7:0] exp);
    logic [7:0] r;
    xfer(tx, r);
    check(tag, 32'(r), 32'(exp));
  endtask

  task automatic cmd_r1(input string tag, input logic [5:0] idx,
                        input logic [31:0] arg, input logic [7:0] crc,
                        input logic [7:0] r1);
    send_cmd(idx, arg, crc);
    expect_byte({tag, "_ncr"}, 8'hFF, 8'hFF);
    expect_byte({tag, "_r1"}, 8'hFF, r1);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] acmd_exp [3];
    int         cv0;
    int         wr0;
    acmd_exp[0] = 8'h01;
    acmd_exp[1] = 8'h01;
    acmd_exp[2] = 8'h00;
    spi.spi_clk = 1'b0;
    spi.cs      = 1'b1;
    spi.mosi    = 1'b1;

    repeat (4) @(negedge clk);
    check("rst_miso", 32'(spi.miso), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_index", 32'(cmd_index), 32'd0);
    check("rst_blk_addr", blk_addr, 32'd0);
    check("rst_byte_idx", 32'(byte_idx), 32'd0);
    check("rst_init", 32'(initialized), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    spi.cs = 1'b0;
    #(2 * HALF);
    repeat (10) expect_byte("dummy", 8'hFF, 8'hFF);

    cv0 = cv_cnt;
    cmd_r1("cmd0", 6'd0, 32'h0, 8'h95, 8'h01);
    check("cmd0_cv_cnt", 32'(cv_cnt - cv0), 32'd1);
    check("cmd0_cv_idx", 32'(cv_idx), 32'd0);

    cmd_r1("cmd8", 6'd8, 32'h0000_01AA, 8'h87, 8'h01);
    expect_byte("cmd8_b1", 8'hFF, 8'h00);
    expect_byte("cmd8_b2", 8'hFF, 8'h00);
    expect_byte("cmd8_b3", 8'hFF, 8'h01);
    expect_byte("cmd8_b4", 8'hFF, 8'hAA);
    check("cmd8_cv_idx", 32'(cv_idx), 32'd8);

    for (int i = 0; i < 3; i++) begin
      cmd_r1("cmd55", 6'd55, 32'h0, 8'h65, 8'h01);
      cmd_r1("acmd41", 6'd41, 32'h4000_0000, 8'h77, acmd_exp[i]);
    end
    check("init_after_acmd41", 32'(initialized), 32'd1);

    cmd_r1("cmd58", 6'd58, 32'h0, 8'hFD, 8'h00);
    expect_byte("ocr_b0", 8'hFF, 8'hC0);
    expect_byte("ocr_b1", 8'hFF, 8'hFF);
    expect_byte("ocr_b2", 8'hFF, 8'h80);
    expect_byte("ocr_b3", 8'hFF, 8'h00);

    cmd_r1("cmd17", 6'd17, 32'h0000_0010, 8'h01, 8'h00);
    check("cmd17_blk_addr", blk_addr, 32'h0000_0010);
    expect_byte("rd_gap0", 8'hFF, 8'hFF);
    expect_byte("rd_gap1", 8'hFF, 8'hFF);
    expect_byte("rd_token", 8'hFF, 8'hFE);
    for (int i = 0; i < 512; i++) expect_byte("rd_data", 8'hFF, 8'(i));
    expect_byte("rd_crc0", 8'hFF, 8'hFF);
    expect_byte("rd_crc1", 8'hFF, 8'hFF);
    expect_byte("rd_idle", 8'hFF, 8'hFF);

    wr_exp_idx = 9'd0;
    wr0 = wr_cnt;
    cmd_r1("cmd24", 6'd24, 32'h0000_0005, 8'h01, 8'h00);
    check("cmd24_blk_addr", blk_addr, 32'h0000_0005);
    expect_byte("wr_token_tx", 8'hFE, 8'hFF);
    repeat (512) xfer(8'hA5, r);
    xfer(8'hFF, r);
    xfer(8'hFF, r);
    expect_byte("wr_dresp", 8'hFF, 8'h05);
    for (int i = 0; i < 4; i++) expect_byte("wr_busy", 8'hFF, 8'h00);
    expect_byte("wr_idle", 8'hFF, 8'hFF);
    check("wr_count", 32'(wr_cnt - wr0), 32'd512);
    check("wr_idx_wrap", 32'(byte_idx), 32'd0);

    wr_exp_idx = 9'd0;
    wr0 = wr_cnt;
    cmd_r1("cmd24b", 6'd24, 32'h0000_0007, 8'h01, 8'h00);
    xfer(8'hFE, r);
    repeat (100) xfer(8'hA5, r);
    spi.cs = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_wr_count", 32'(wr_cnt - wr0), 32'd100);
    check("abort_byte_idx", 32'(byte_idx), 32'd100);
    check("abort_miso", 32'(spi.miso), 32'd1);
    check("abort_init_kept", 32'(initialized), 32'd1);
    spi.cs = 1'b0;
    #(2 * HALF);

    cv0 = cv_cnt;
    cmd_r1("cmd0b", 6'd0, 32'h0, 8'h95, 8'h01);
    check("cmd0b_cv_cnt", 32'(cv_cnt - cv0), 32'd1);
    check("cmd0b_init", 32'(initialized), 32'd0);

    cmd_r1("cmd17_noinit", 6'd17, 32'h0, 8'h01, 8'h05);
    check("cmd17_noinit_idx", 32'(cv_idx), 32'd17);
    check("cmd17_noinit_addr", blk_addr, 32'h0000_0007);
    cmd_r1("cmd41_noapp", 6'd41, 32'h4000_0000, 8'h01, 8'h05);
    expect_byte("final_idle", 8'hFF, 8'hFF);

    spi.cs = 1'b1;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
